// File: rtl/font_rom_arbiter.sv
// Shares one combinational font ROM between two glyph-fetch requesters.
// Latency: accept edge -> ROM address on next edge -> rsp_valid after the edge after that (+1 edge when losing arbitration).
// Backpressure: one outstanding entry per requester; ready drops while its slot is pending.
module font_rom_arbiter #(
   parameter int CODE_W     = 5,
   parameter int ROW_W      = 3,
   parameter int FIXED_PRIO = 0,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [CODE_W-1:0] req0_code,
   input  logic [ROW_W-1:0]  req0_row,
   output logic              rsp0_valid,
   output logic [7:0]        rsp0_bitmap,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [CODE_W-1:0] req1_code,
   input  logic [ROW_W-1:0]  req1_row,
   output logic              rsp1_valid,
   output logic [7:0]        rsp1_bitmap,
   output logic [CODE_W-1:0] rom_char_code,
   output logic [ROW_W-1:0]  rom_row,
   input  logic [7:0]        rom_bitmap,
   output logic [CNT_W-1:0]  conflict_cnt
);

   // Slot state
   logic              pend0_q, pend0_d;
   logic              pend1_q, pend1_d;
   logic [CODE_W-1:0] code0_q, code0_d;
   logic [CODE_W-1:0] code1_q, code1_d;
   logic [ROW_W-1:0]  row0_q, row0_d;
   logic [ROW_W-1:0]  row1_q, row1_d;

   // Issue stage
   logic              issue_valid_q, issue_valid_d;
   logic              issue_id_q, issue_id_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [CODE_W-1:0] rom_char_code_q, rom_char_code_d;
   logic [ROW_W-1:0]  rom_row_q, rom_row_d;
   logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

   // Response stage
   logic              rsp0_valid_q, rsp0_valid_d;
   logic              rsp1_valid_q, rsp1_valid_d;
   logic [7:0]        rsp0_bitmap_q, rsp0_bitmap_d;
   logic [7:0]        rsp1_bitmap_q, rsp1_bitmap_d;

   logic accept0, accept1;
   logic grant, both_pend, winner;

   // Ready depends only on registered slot state so there is no valid->ready path.
   assign req0_ready = rst_n & ~pend0_q;
   assign req1_ready = rst_n & ~pend1_q;

   assign rsp0_valid    = rsp0_valid_q;
   assign rsp1_valid    = rsp1_valid_q;
   assign rsp0_bitmap   = rsp0_bitmap_q;
   assign rsp1_bitmap   = rsp1_bitmap_q;
   assign rom_char_code = rom_char_code_q;
   assign rom_row       = rom_row_q;
   assign conflict_cnt  = conflict_cnt_q;

   // Next-state for accept, arbitration, issue and response stages.
   always_comb begin
      accept0   = req0_valid & req0_ready;
      accept1   = req1_valid & req1_ready;
      both_pend = pend0_q & pend1_q;
      grant     = pend0_q | pend1_q;
      winner    = 1'b0;
      if (both_pend) begin
         winner = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr_q;
      end else begin
         winner = ~pend0_q;
      end

      // A slot can't be accepted and issued on the same edge: accept needs
      // ~pend, issue needs pend.
      pend0_d = pend0_q;
      pend1_d = pend1_q;
      if (grant && !winner) pend0_d = 1'b0;
      if (grant &&  winner) pend1_d = 1'b0;
      if (accept0)          pend0_d = 1'b1;
      if (accept1)          pend1_d = 1'b1;

      code0_d = accept0 ? req0_code : code0_q;
      row0_d  = accept0 ? req0_row  : row0_q;
      code1_d = accept1 ? req1_code : code1_q;
      row1_d  = accept1 ? req1_row  : row1_q;

      issue_valid_d   = grant;
      issue_id_d      = issue_id_q;
      rr_ptr_d        = rr_ptr_q;
      rom_char_code_d = rom_char_code_q;
      rom_row_d       = rom_row_q;
      if (grant) begin
         issue_id_d      = winner;
         rr_ptr_d        = ~winner;
         rom_char_code_d = winner ? code1_q : code0_q;
         rom_row_d       = winner ? row1_q  : row0_q;
      end

      conflict_cnt_d = conflict_cnt_q;
      if (both_pend && (conflict_cnt_q != {CNT_W{1'b1}})) begin
         conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
      end

      // ROM data is valid in the cycle its address is registered.
      rsp0_valid_d  = issue_valid_q & ~issue_id_q;
      rsp1_valid_d  = issue_valid_q &  issue_id_q;
      rsp0_bitmap_d = rsp0_valid_d ? rom_bitmap : rsp0_bitmap_q;
      rsp1_bitmap_d = rsp1_valid_d ? rom_bitmap : rsp1_bitmap_q;
   end

   // State registers; reset discards pending and in-flight lookups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend0_q         <= 1'b0;
         pend1_q         <= 1'b0;
         code0_q         <= '0;
         code1_q         <= '0;
         row0_q          <= '0;
         row1_q          <= '0;
         issue_valid_q   <= 1'b0;
         issue_id_q      <= 1'b0;
         rr_ptr_q        <= 1'b0;
         rom_char_code_q <= '0;
         rom_row_q       <= '0;
         conflict_cnt_q  <= '0;
         rsp0_valid_q    <= 1'b0;
         rsp1_valid_q    <= 1'b0;
         rsp0_bitmap_q   <= '0;
         rsp1_bitmap_q   <= '0;
      end else begin
         pend0_q         <= pend0_d;
         pend1_q         <= pend1_d;
         code0_q         <= code0_d;
         code1_q         <= code1_d;
         row0_q          <= row0_d;
         row1_q          <= row1_d;
         issue_valid_q   <= issue_valid_d;
         issue_id_q      <= issue_id_d;
         rr_ptr_q        <= rr_ptr_d;
         rom_char_code_q <= rom_char_code_d;
         rom_row_q       <= rom_row_d;
         conflict_cnt_q  <= conflict_cnt_d;
         rsp0_valid_q    <= rsp0_valid_d;
         rsp1_valid_q    <= rsp1_valid_d;
         rsp0_bitmap_q   <= rsp0_bitmap_d;
         rsp1_bitmap_q   <= rsp1_bitmap_d;
      end
   end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter: round-robin instance (a_*) and a
// fixed-priority instance with a 4-bit conflict counter (b_*).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_font_rom_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Round-robin instance
   logic       a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
   logic [4:0] a_req0_code, a_req1_code, a_rom_char_code;
   logic [2:0] a_req0_row, a_req1_row, a_rom_row;
   logic       a_rsp0_valid, a_rsp1_valid;
   logic [7:0] a_rsp0_bitmap, a_rsp1_bitmap, a_rom_bitmap;
   logic [15:0] a_conflict_cnt;

   // Fixed-priority instance
   logic       b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
   logic [4:0] b_req0_code, b_req1_code, b_rom_char_code;
   logic [2:0] b_req0_row, b_req1_row, b_rom_row;
   logic       b_rsp0_valid, b_rsp1_valid;
   logic [7:0] b_rsp0_bitmap, b_rsp1_bitmap, b_rom_bitmap;
   logic [3:0] b_conflict_cnt;

   int total = 0;
   int fails = 0;

   // Reference font ROM contents (arbitrary but distinct per code/row)
   function automatic logic [7:0] rom_f(input logic [4:0] c, input logic [2:0] r);
      return {c, r} ^ 8'h3C;
   endfunction

   assign a_rom_bitmap = rom_f(a_rom_char_code, a_rom_row);
   assign b_rom_bitmap = rom_f(b_rom_char_code, b_rom_row);

   font_rom_arbiter #(.CODE_W(5), .ROW_W(3), .FIXED_PRIO(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(a_req0_valid), .req0_ready(a_req0_ready),
      .req0_code(a_req0_code), .req0_row(a_req0_row),
      .rsp0_valid(a_rsp0_valid), .rsp0_bitmap(a_rsp0_bitmap),
      .req1_valid(a_req1_valid), .req1_ready(a_req1_ready),
      .req1_code(a_req1_code), .req1_row(a_req1_row),
      .rsp1_valid(a_rsp1_valid), .rsp1_bitmap(a_rsp1_bitmap),
      .rom_char_code(a_rom_char_code), .rom_row(a_rom_row),
      .rom_bitmap(a_rom_bitmap), .conflict_cnt(a_conflict_cnt)
   );

   font_rom_arbiter #(.CODE_W(5), .ROW_W(3), .FIXED_PRIO(1), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
      .req0_code(b_req0_code), .req0_row(b_req0_row),
      .rsp0_valid(b_rsp0_valid), .rsp0_bitmap(b_rsp0_bitmap),
      .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
      .req1_code(b_req1_code), .req1_row(b_req1_row),
      .rsp1_valid(b_rsp1_valid), .rsp1_bitmap(b_rsp1_bitmap),
      .rom_char_code(b_rom_char_code), .rom_row(b_rom_row),
      .rom_bitmap(b_rom_bitmap), .conflict_cnt(b_conflict_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent, got, exp_cnt;
      logic exp_rdy, accepted;
      logic [4:0] c0, c1;
      logic [2:0] r0, r1;

      a_req0_valid = 0; a_req0_code = 0; a_req0_row = 0;
      a_req1_valid = 0; a_req1_code = 0; a_req1_row = 0;
      b_req0_valid = 0; b_req0_code = 0; b_req0_row = 0;
      b_req1_valid = 0; b_req1_code = 0; b_req1_row = 0;

      // ---- Reset state ----
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      tick();
      tick();
      check("rst_ready0", a_req0_ready, 0);
      check("rst_ready1", a_req1_ready, 0);
      check("rst_rom_code", a_rom_char_code, 0);
      check("rst_rom_row", a_rom_row, 0);
      check("rst_rsp0_valid", a_rsp0_valid, 0);
      check("rst_rsp0_bitmap", a_rsp0_bitmap, 0);
      check("rst_conflict", a_conflict_cnt, 0);
      rst_n = 1'b1;
      #1;
      check("rel_ready0", a_req0_ready, 1);
      check("rel_ready1", a_req1_ready, 1);

      // ---- Single lookup: code 14 row 3 ----
      a_req0_valid = 1; a_req0_code = 5'd14; a_req0_row = 3'd3;
      tick();                                   // E0: accept
      a_req0_valid = 0;
      check("single_ready_low", a_req0_ready, 0);
      tick();                                   // E1: issue
      check("single_rom_code", a_rom_char_code, 14);
      check("single_rom_row", a_rom_row, 3);
      check("single_rsp_early", a_rsp0_valid, 0);
      check("single_ready_back", a_req0_ready, 1);
      tick();                                   // E2: response
      check("single_rsp0_valid", a_rsp0_valid, 1);
      check("single_rsp0_bitmap", a_rsp0_bitmap, rom_f(5'd14, 3'd3));
      check("single_rsp1_quiet", a_rsp1_valid, 0);
      tick();
      check("single_rsp0_pulse", a_rsp0_valid, 0);
      check("single_bitmap_hold", a_rsp0_bitmap, rom_f(5'd14, 3'd3));

      // ---- Round-robin contention from reset ----
      rst_n = 0; #1; rst_n = 1;
      a_req0_valid = 1; a_req0_code = 5'd1; a_req0_row = 3'd0;
      a_req1_valid = 1; a_req1_code = 5'd2; a_req1_row = 3'd0;
      tick();                                   // both accepted
      a_req0_valid = 0; a_req1_valid = 0;
      tick();                                   // req0 wins (rr_ptr = 0)
      check("rr1_first_code", a_rom_char_code, 1);
      check("rr1_conflict", a_conflict_cnt, 1);
      tick();                                   // req1 issued
      check("rr1_second_code", a_rom_char_code, 2);
      check("rr1_rsp0_valid", a_rsp0_valid, 1);
      check("rr1_rsp0_bitmap", a_rsp0_bitmap, rom_f(5'd1, 3'd0));
      check("rr1_rsp1_early", a_rsp1_valid, 0);
      tick();
      check("rr1_rsp1_valid", a_rsp1_valid, 1);
      check("rr1_rsp1_bitmap", a_rsp1_bitmap, rom_f(5'd2, 3'd0));
      check("rr1_rsp0_done", a_rsp0_valid, 0);
      check("rr1_conflict_hold", a_conflict_cnt, 1);
      // Lone req0 grant leaves the pointer on requester 1.
      a_req0_valid = 1; a_req0_code = 5'd7; a_req0_row = 3'd1;
      tick();
      a_req0_valid = 0;
      tick();
      tick();
      check("rr_lone_rsp0", a_rsp0_bitmap, rom_f(5'd7, 3'd1));
      tick();
      a_req0_valid = 1; a_req0_code = 5'd3; a_req0_row = 3'd2;
      a_req1_valid = 1; a_req1_code = 5'd4; a_req1_row = 3'd5;
      tick();
      a_req0_valid = 0; a_req1_valid = 0;
      tick();                                   // req1 wins this time
      check("rr2_first_code", a_rom_char_code, 4);
      check("rr2_first_row", a_rom_row, 5);
      check("rr2_conflict", a_conflict_cnt, 2);
      tick();
      check("rr2_second_code", a_rom_char_code, 3);
      check("rr2_rsp1_valid", a_rsp1_valid, 1);
      check("rr2_rsp1_bitmap", a_rsp1_bitmap, rom_f(5'd4, 3'd5));
      tick();
      check("rr2_rsp0_valid", a_rsp0_valid, 1);
      check("rr2_rsp0_bitmap", a_rsp0_bitmap, rom_f(5'd3, 3'd2));
      tick();

      // ---- Continuous req0 stream, codes 0..9 ----
      sent = 0; got = 0; exp_rdy = 1;
      a_req0_valid = 1; a_req0_code = 5'd0; a_req0_row = 3'd0;
      for (int i = 0; i < 30; i++) begin
         if (a_rsp0_valid) begin
            check("stream_bitmap", a_rsp0_bitmap, rom_f(5'(got), 3'(got)));
            got++;
         end
         check("stream_rsp1_quiet", a_rsp1_valid, 0);
         if (sent < 10) begin
            check("stream_ready", a_req0_ready, exp_rdy);
            exp_rdy = ~exp_rdy;
         end
         accepted = a_req0_valid & a_req0_ready;
         tick();
         if (accepted) sent++;
         a_req0_code  = 5'(sent);
         a_req0_row   = 3'(sent);
         a_req0_valid = (sent < 10);
      end
      check("stream_count", got, 10);

      // ---- Reset mid-operation ----
      a_req0_valid = 1; a_req0_code = 5'd9; a_req0_row = 3'd4;
      tick();                                   // accept
      a_req0_valid = 0;
      tick();                                   // issued, response in flight
      check("midrst_issued", a_rom_char_code, 9);
      rst_n = 0;
      #1;
      check("midrst_rom_code", a_rom_char_code, 0);
      check("midrst_rom_row", a_rom_row, 0);
      check("midrst_ready", a_req0_ready, 0);
      check("midrst_bitmap", a_rsp0_bitmap, 0);
      tick();
      rst_n = 1;
      #1;
      check("midrst_ready_back", a_req0_ready, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("midrst_no_rsp0", a_rsp0_valid, 0);
         check("midrst_no_rsp1", a_rsp1_valid, 0);
      end

      // ---- Fixed priority + 4-bit counter saturation (20 conflicts) ----
      exp_cnt = 0;
      for (int r = 0; r < 20; r++) begin
         c0 = 5'(r); r0 = 3'(r);
         c1 = 5'(r) ^ 5'h1F; r1 = 3'(r + 3);
         check("fp_both_ready", {b_req0_ready, b_req1_ready}, 2'b11);
         b_req0_valid = 1; b_req0_code = c0; b_req0_row = r0;
         b_req1_valid = 1; b_req1_code = c1; b_req1_row = r1;
         tick();                                // both accepted
         b_req0_valid = 0; b_req1_valid = 0;
         tick();                                // req0 always wins
         exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
         check("fp_winner0", b_rom_char_code, c0);
         check("fp_conflict", b_conflict_cnt, exp_cnt);
         tick();                                // req1 served next cycle
         check("fp_then1", b_rom_char_code, c1);
         check("fp_rsp0_bitmap", {b_rsp0_valid, b_rsp0_bitmap}, {1'b1, rom_f(c0, r0)});
         tick();
         check("fp_rsp1_bitmap", {b_rsp1_valid, b_rsp1_bitmap}, {1'b1, rom_f(c1, r1)});
      end
      check("fp_saturated", b_conflict_cnt, 4'hF);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
